// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with one-hot op decode and iterative shifter
// Ports: clk, rst (async, active high), flush
//        in_valid/in_ready + alu_operation, alu_mask, op_a, op_b : operation input
//        out_valid/out_ready + result, zero, op_err              : registered result output
module alu_exec_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 10,
  parameter int SHAMT_WIDTH  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ALU_OP_WIDTH-1:0] alu_operation,
  input  logic [DATA_WIDTH-1:0]   alu_mask,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    zero,
  output logic                    op_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              sh_op_q, sh_op_d;   // {SRA, SRL, SLL}
  logic [DATA_WIDTH-1:0]   mask_q, mask_d;
  logic [DATA_WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    zero_q, zero_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic                    onehot;
  logic                    is_shift;
  logic [SHAMT_WIDTH-1:0]  shamt;
  logic [DATA_WIDTH-1:0]   value;
  logic [DATA_WIDTH-1:0]   step;

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign op_err    = err_q;

  assign shamt    = op_b[SHAMT_WIDTH-1:0];
  assign is_shift = |alu_operation[5:3];
  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign onehot   = (|alu_operation) &&
                    ((alu_operation & (alu_operation - {{(ALU_OP_WIDTH-1){1'b0}}, 1'b1})) == '0);

  // Single-cycle datapath; a shift reaching here has shamt==0 and passes op_a through.
  always_comb begin
    value = '0;
    if (alu_operation[0])      value = op_a + op_b;
    else if (alu_operation[1]) value = op_a - op_b;
    else if (alu_operation[2]) value = op_a ^ op_b;
    else if (alu_operation[6]) value = op_a | op_b;
    else if (alu_operation[7]) value = op_a & op_b;
    else if (alu_operation[8]) value = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
    else if (alu_operation[9]) value = {{(DATA_WIDTH-1){1'b0}}, (op_a < op_b)};
    else if (is_shift)         value = op_a;
  end

  // One bit of shift per cycle for the captured shift kind.
  always_comb begin
    step = work_q;
    if (sh_op_q[0])      step = {work_q[DATA_WIDTH-2:0], 1'b0};
    else if (sh_op_q[1]) step = {1'b0, work_q[DATA_WIDTH-1:1]};
    else if (sh_op_q[2]) step = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    sh_op_d  = sh_op_q;
    mask_d   = mask_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;

    if (flush) begin
      // Result and zero deliberately hold; only the handshake and error are cleared.
      state_d = IDLE;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sh_op_d = alu_operation[5:3];
            mask_d  = alu_mask;
            if (!onehot) begin
              result_d = '0;
              zero_d   = 1'b1;
              err_d    = 1'b1;
              state_d  = DONE;
            end else if (is_shift && (shamt != '0)) begin
              work_d  = op_a;
              cnt_d   = shamt;
              state_d = SHIFT;
            end else begin
              result_d = value & alu_mask;
              zero_d   = (value == '0);
              err_d    = 1'b0;
              state_d  = DONE;
            end
          end
        end
        SHIFT: begin
          work_d = step;
          cnt_d  = cnt_q - {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};
          if (cnt_q == {{(SHAMT_WIDTH-1){1'b0}}, 1'b1}) begin
            result_d = step & mask_q;
            zero_d   = (step == '0);
            err_d    = 1'b0;
            state_d  = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sh_op_q  <= '0;
      mask_q   <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_op_q  <= sh_op_d;
      mask_q   <= mask_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard testbench for alu_exec_unit
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  alu_operation;
  logic [31:0] alu_mask;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        op_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_operation(alu_operation), .alu_mask(alu_mask),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .op_err(op_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [9:0] op, input logic [31:0] m,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] v;
    int          sh;
    sh = int'(b[4:0]);
    v  = '0;
    if ($countones(op) != 1) begin
      e.res = '0; e.z = 1'b1; e.err = 1'b1; e.lat = 1;
      return e;
    end
    case (op)
      10'h001: v = a + b;
      10'h002: v = a - b;
      10'h004: v = a ^ b;
      10'h008: v = a << sh;
      10'h010: v = a >> sh;
      10'h020: v = $signed(a) >>> sh;
      10'h040: v = a | b;
      10'h080: v = a & b;
      10'h100: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: v = (a < b) ? 32'd1 : 32'd0;
    endcase
    e.res = v & m;
    e.z   = (v == 0);
    e.err = 1'b0;
    e.lat = ((op & 10'h038) != 0 && sh != 0) ? sh + 1 : 1;
    return e;
  endfunction

  // Drive one op, measure latency, compare against the scoreboard, hold in DONE
  // for 'hold' cycles, then either retire it or flush it.
  task automatic do_op(input logic [9:0] op, input logic [31:0] m, input logic [31:0] a,
                       input logic [31:0] b, input int hold, input bit flush_done);
    exp_t e;
    int   lat;
    @(negedge clk);
    alu_operation = op; alu_mask = m; op_a = a; op_b = b;
    in_valid = 1'b1; out_ready = 1'b0;
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    sb.push_back(model(op, m, a, b));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("result", result, e.res);
    chk("zero", {31'b0, zero}, {31'b0, e.z});
    chk("op_err", {31'b0, op_err}, {31'b0, e.err});
    chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
    last_res = e.res;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_result", result, e.res);
      chk("bp_zero", {31'b0, zero}, {31'b0, e.z});
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    if (flush_done) flush = 1'b1;
    else out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    chk("retire_valid", {31'b0, out_valid}, 32'd0);
    chk("retire_in_ready", {31'b0, in_ready}, 32'd1);
    if (flush_done) begin
      chk("flush_op_err", {31'b0, op_err}, 32'd0);
      chk("flush_result_hold", result, e.res);
    end
  endtask

  initial begin
    int seen;
    logic [9:0] rop;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_operation = '0; alu_mask = '0; op_a = '0; op_b = '0;
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
    chk("rst_op_err", {31'b0, op_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(10'h001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd1, 0, 0);
    do_op(10'h001, 32'h0000_00FF, 32'h7FFF_FFFF, 32'd1, 0, 0);
    do_op(10'h002, 32'hFFFF_FFFF, 32'h1234, 32'h1234, 0, 0);
    do_op(10'h100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, 0);
    do_op(10'h200, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, 0);
    do_op(10'h020, 32'hFFFF_FFFF, 32'h8000_0000, 32'd31, 0, 0);
    do_op(10'h008, 32'hFFFF_FFFF, 32'd1, 32'h20, 0, 0);
    do_op(10'h004, 32'hFFFF_FFFF, 32'hA5A5_0F0F, 32'h0F0F_A5A5, 5, 0);
    do_op(10'h003, 32'hFFFF_FFFF, 32'h5, 32'h6, 0, 0);
    do_op(10'h000, 32'hFFFF_FFFF, 32'h5, 32'h6, 0, 0);
    do_op(10'h000, 32'hFFFF_FFFF, 32'h5, 32'h6, 2, 1);

    for (int i = 0; i < 16; i++) begin
      rop = 10'h001 << $urandom_range(0, 9);
      do_op(rop, ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF,
            $urandom, (rop[5:3] != 0) ? 32'($urandom_range(0, 40)) : $urandom, 0, 0);
    end

    // Flush in the middle of a 20-bit SRL.
    @(negedge clk);
    alu_operation = 10'h010; alu_mask = 32'hFFFF_FFFF; op_a = 32'hF000_0000; op_b = 32'd20;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("mid_flush_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_flush_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_flush_result", result, last_res);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_flush_never_valid", seen, 0);

    // Async reset in the middle of a shift, with a nonzero prior result.
    do_op(10'h001, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0);
    @(negedge clk);
    alu_operation = 10'h020; op_a = 32'h8000_0000; op_b = 32'd20;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_zero", {31'b0, zero}, 32'd0);
    chk("arst_op_err", {31'b0, op_err}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(10'h080, 32'hFFFF_FFFF, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
